// File: rtl/sha1_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha1_round_ctrl
// Description : Block sequencer for the SHA-1 compression datapath: loads
//               16 message words, steps 80 rounds, updates H, pulses done.
//               Optional abort support is compiled in with SHA1_CTRL_ABORT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module sha1_round_ctrl #(
    parameter int ROUNDS    = 80,
    parameter int MSG_WORDS = 16,
    parameter int CNT_W     = 7
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             first_block,
    input  logic             word_valid,
`ifdef SHA1_CTRL_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             word_ready,
    output logic [3:0]       word_idx,
    output logic             w_load,
    output logic             h_init,
    output logic             round_en,
    output logic [CNT_W-1:0] round_idx,
    output logic [1:0]       f_sel,
    output logic             w_expand,
    output logic             h_update,
    output logic             done,
    output logic             busy
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_load  = 3'd1;
    localparam logic [2:0] c_round = 3'd2;
    localparam logic [2:0] c_final = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    localparam logic [3:0]       c_last_word  = 4'(MSG_WORDS - 1);
    localparam logic [CNT_W-1:0] c_last_round = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] c_msg_words  = CNT_W'(MSG_WORDS);
    // f/K group boundaries: the 80 rounds split into four equal quarters
    localparam logic [CNT_W-1:0] c_q1         = CNT_W'(ROUNDS / 4);
    localparam logic [CNT_W-1:0] c_q2         = CNT_W'(ROUNDS / 2);
    localparam logic [CNT_W-1:0] c_q3         = CNT_W'((3 * ROUNDS) / 4);

    logic [2:0]       r_state_q;
    logic [2:0]       w_state_d;
    logic [3:0]       r_word_idx_q;
    logic [3:0]       w_word_idx_d;
    logic [CNT_W-1:0] r_round_idx_q;
    logic [CNT_W-1:0] w_round_idx_d;
    logic             r_h_init_q;
    logic             w_h_init_d;
`ifdef SHA1_CTRL_ABORT_EN
    logic             r_aborted_q;
    logic             w_aborted_d;
`endif

    logic             w_in_load;
    logic             w_in_round;
    logic             w_accept;

    assign w_in_load  = (r_state_q == c_load);
    assign w_in_round = (r_state_q == c_round);
    assign w_accept   = w_in_load & word_valid;

    always_comb begin
        w_state_d     = r_state_q;
        w_word_idx_d  = r_word_idx_q;
        w_round_idx_d = r_round_idx_q;
        w_h_init_d    = 1'b0;
`ifdef SHA1_CTRL_ABORT_EN
        w_aborted_d   = 1'b0;
`endif
        case (r_state_q)
            c_idle: begin
                if (start) begin
                    w_state_d  = c_load;
                    w_h_init_d = first_block;
                end
            end
            c_load: begin
                if (word_valid) begin
                    if (r_word_idx_q == c_last_word) begin
                        w_state_d     = c_round;
                        w_word_idx_d  = 4'd0;
                        w_round_idx_d = '0;
                    end else begin
                        w_word_idx_d = r_word_idx_q + 4'd1;
                    end
                end
            end
            c_round: begin
                if (r_round_idx_q == c_last_round) begin
                    w_state_d = c_final;
                end else begin
                    w_round_idx_d = r_round_idx_q + CNT_W'(1);
                end
            end
            c_final: begin
                w_state_d = c_done;
            end
            c_done: begin
                w_state_d     = c_idle;
                w_word_idx_d  = 4'd0;
                w_round_idx_d = '0;
            end
            default: begin
                w_state_d     = c_idle;
                w_word_idx_d  = 4'd0;
                w_round_idx_d = '0;
            end
        endcase
`ifdef SHA1_CTRL_ABORT_EN
        // Abort overrides every transition, including ROUND -> FINAL
        if (abort && (r_state_q != c_idle)) begin
            w_state_d     = c_idle;
            w_word_idx_d  = 4'd0;
            w_round_idx_d = '0;
            w_h_init_d    = 1'b0;
            w_aborted_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q     <= c_idle;
            r_word_idx_q  <= 4'd0;
            r_round_idx_q <= '0;
            r_h_init_q    <= 1'b0;
`ifdef SHA1_CTRL_ABORT_EN
            r_aborted_q   <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_word_idx_q  <= w_word_idx_d;
            r_round_idx_q <= w_round_idx_d;
            r_h_init_q    <= w_h_init_d;
`ifdef SHA1_CTRL_ABORT_EN
            r_aborted_q   <= w_aborted_d;
`endif
        end
    end

    always_comb begin
        f_sel = 2'd0;
        if (w_in_round) begin
            if (r_round_idx_q < c_q1) begin
                f_sel = 2'd0;
            end else if (r_round_idx_q < c_q2) begin
                f_sel = 2'd1;
            end else if (r_round_idx_q < c_q3) begin
                f_sel = 2'd2;
            end else begin
                f_sel = 2'd3;
            end
        end
    end

    assign word_ready = w_in_load;
    assign w_load     = w_accept;
    assign word_idx   = r_word_idx_q;
    assign h_init     = r_h_init_q;
    assign round_en   = w_in_round;
    assign round_idx  = r_round_idx_q;
    assign w_expand   = w_in_round & (r_round_idx_q >= c_msg_words);
    assign h_update   = (r_state_q == c_final);
    assign done       = (r_state_q == c_done);
    assign busy       = (r_state_q != c_idle);
`ifdef SHA1_CTRL_ABORT_EN
    assign aborted    = r_aborted_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha1_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha1_round_ctrl
// Description : Directed, table-driven bench for sha1_round_ctrl; abort cases
//               are included when SHA1_CTRL_ABORT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sha1_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       first_block = 1'b0;
    logic       word_valid = 1'b0;
    logic       word_ready;
    logic [3:0] word_idx;
    logic       w_load;
    logic       h_init;
    logic       round_en;
    logic [6:0] round_idx;
    logic [1:0] f_sel;
    logic       w_expand;
    logic       h_update;
    logic       done;
    logic       busy;
`ifdef SHA1_CTRL_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
    logic       ab_tr [0:139];
`endif

    int checks = 0;
    int errors = 0;
    int abort_cyc = -1;

    logic [20:0] tr [0:139];

    typedef struct {
        int          cyc;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl [16];

    always #5 clk = ~clk;

    sha1_round_ctrl #(.ROUNDS(80), .MSG_WORDS(16), .CNT_W(7)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start       (start),
        .first_block (first_block),
        .word_valid  (word_valid),
`ifdef SHA1_CTRL_ABORT_EN
        .abort       (abort),
        .aborted     (aborted),
`endif
        .word_ready  (word_ready),
        .word_idx    (word_idx),
        .w_load      (w_load),
        .h_init      (h_init),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .f_sel       (f_sel),
        .w_expand    (w_expand),
        .h_update    (h_update),
        .done        (done),
        .busy        (busy)
    );

    // Bit layout: rdy[20] wl[19] wi[18:15] hi[14] re[13] ri[12:6] fs[5:4] we[3] hu[2] dn[1] bs[0]
    function automatic logic [20:0] pk(bit rdy, bit wl, int wi, bit hi, bit re,
                                       int ri, int fs, bit we, bit hu, bit dn, bit bs);
        return {rdy, wl, 4'(wi), hi, re, 7'(ri), 2'(fs), we, hu, dn, bs};
    endfunction

    function automatic logic [20:0] cur_out();
        return {word_ready, w_load, word_idx, h_init, round_en, round_idx,
                f_sel, w_expand, h_update, done, busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // mode 0: valid held high; 1: valid toggles; 2: stray start pulses in LOAD/ROUND
    task automatic run(input int mode, input bit fb, input int rst_cyc, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            start       = (c == 0) || (mode == 2 && (c == 5 || c == 50));
            first_block = (mode == 2) ? (c != 0) : fb;
            word_valid  = (mode == 1) ? (c % 2 == 1) : 1'b1;
            rst         = (c == rst_cyc);
`ifdef SHA1_CTRL_ABORT_EN
            abort       = (c == abort_cyc);
`endif
            #1;
            tr[c] = cur_out();
`ifdef SHA1_CTRL_ABORT_EN
            ab_tr[c] = aborted;
`endif
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
        word_valid = 1'b0;
`ifdef SHA1_CTRL_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    function automatic int cnt(input int bitpos, input int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++) n += int'(tr[c][bitpos]);
        return n;
    endfunction

    function automatic int excl_viol(input int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++)
            if (int'(tr[c][19]) + int'(tr[c][13]) + int'(tr[c][2]) + int'(tr[c][1]) > 1) n++;
        return n;
    endfunction

    initial begin
        tbl[0]  = '{0,  pk(0,0,0, 0,0,0, 0,0,0,0,0)};
        tbl[1]  = '{1,  pk(1,1,0, 1,0,0, 0,0,0,0,1)};
        tbl[2]  = '{2,  pk(1,1,1, 0,0,0, 0,0,0,0,1)};
        tbl[3]  = '{16, pk(1,1,15,0,0,0, 0,0,0,0,1)};
        tbl[4]  = '{17, pk(0,0,0, 0,1,0, 0,0,0,0,1)};
        tbl[5]  = '{32, pk(0,0,0, 0,1,15,0,0,0,0,1)};
        tbl[6]  = '{33, pk(0,0,0, 0,1,16,0,1,0,0,1)};
        tbl[7]  = '{36, pk(0,0,0, 0,1,19,0,1,0,0,1)};
        tbl[8]  = '{37, pk(0,0,0, 0,1,20,1,1,0,0,1)};
        tbl[9]  = '{57, pk(0,0,0, 0,1,40,2,1,0,0,1)};
        tbl[10] = '{76, pk(0,0,0, 0,1,59,2,1,0,0,1)};
        tbl[11] = '{77, pk(0,0,0, 0,1,60,3,1,0,0,1)};
        tbl[12] = '{96, pk(0,0,0, 0,1,79,3,1,0,0,1)};
        tbl[13] = '{97, pk(0,0,0, 0,0,79,0,0,1,0,1)};
        tbl[14] = '{98, pk(0,0,0, 0,0,79,0,0,0,1,1)};
        tbl[15] = '{99, pk(0,0,0, 0,0,0, 0,0,0,0,0)};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_state", 32'(cur_out()), 32'd0);
        @(posedge clk);
        #1;

        // Full block, valid held high, first block
        run(0, 1'b1, -1, 101);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t1_cyc%0d", tbl[i].cyc), 32'(tr[tbl[i].cyc]), 32'(tbl[i].exp));
        chk("t1_wload_cnt",  cnt(19, 101), 16);
        chk("t1_rounden_cnt", cnt(13, 101), 80);
        chk("t1_hupd_cnt",   cnt(2, 101), 1);
        chk("t1_done_cnt",   cnt(1, 101), 1);
        chk("t1_hinit_cnt",  cnt(14, 101), 1);
        chk("t1_excl",       excl_viol(101), 0);

        // Gapped word_valid
        run(1, 1'b1, -1, 120);
        chk("t2_idx_gap",     32'(tr[2][18:15]), 1);
        chk("t2_wload_gap",   32'(tr[2][19]), 0);
        chk("t2_idx_c3",      32'(tr[3][18:15]), 1);
        chk("t2_last_accept", 32'(tr[31][19:15]), 32'h1F);
        chk("t2_no_round_31", 32'(tr[31][13]), 0);
        chk("t2_round_32",    32'(tr[32][13:6]), 32'h80);
        chk("t2_wload_cnt",   cnt(19, 120), 16);
        chk("t2_rounden_cnt", cnt(13, 120), 80);
        chk("t2_done_113",    32'(tr[113][1]), 1);

        // Stray start pulses, first_block=0 on the accepted start
        run(2, 1'b0, -1, 130);
        chk("t4_hinit_cnt", cnt(14, 130), 0);
        chk("t4_done_cnt",  cnt(1, 130), 1);
        chk("t4_done_98",   32'(tr[98][1]), 1);
        chk("t4_busy_cnt",  cnt(0, 130), 98);

        // Reset at round_idx 37
        run(0, 1'b1, 54, 110);
        chk("t5_pre_reset", 32'(tr[54][13:6]), 32'(8'h80 | 8'd37));
        chk("t5_post_reset", 32'(tr[55]), 32'd0);
        chk("t5_hupd_cnt",  cnt(2, 110), 0);
        chk("t5_done_cnt",  cnt(1, 110), 0);
        run(0, 1'b1, -1, 101);
        chk("t5_rerun_done", 32'(tr[98]), 32'(tbl[14].exp));
        chk("t5_rerun_rnd",  cnt(13, 101), 80);

        // start together with reset is dropped
        run(0, 1'b1, 0, 4);
        chk("rst_start_busy", 32'(tr[1]), 32'd0);

`ifdef SHA1_CTRL_ABORT_EN
        abort_cyc = 96;
        run(0, 1'b1, -1, 105);
        abort_cyc = -1;
        chk("t6_abort_pulse", 32'(ab_tr[97]), 1);
        chk("t6_abort_once",  32'(ab_tr[98]), 0);
        chk("t6_busy_after",  32'(tr[97][0]), 0);
        chk("t6_hupd_cnt",    cnt(2, 105), 0);
        chk("t6_done_cnt",    cnt(1, 105), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
